// File: rtl/wb_commit_monitor.sv
// wb_commit_monitor
//   Watches the writeback-stage register-write bus. Every commit is mirrored
//   into a shadow register file and counted. Once no commit has been seen for
//   IDLE_LIMIT cycles, the shadow registers are checked against an expected
//   table, one register per cycle. The result is held as done/pass/fail
//   together with the first mismatching register.
//
//   Optional feature macro: MONITOR_TRACE_EN. When it is defined, every
//   commit {wa3_w, result_w} is also pushed into a TRACE_DEPTH-entry FIFO
//   (trace_pop/trace_valid/trace_data/trace_ovf).
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   reg_write_w, wa3_w,   writeback bus (RegWriteW, WA3W, ResultW)
//   result_w
//   exp_we/addr/data      expected-table write; each write also arms the
//                         check-mask bit for that entry
//   rd_addr, rd_data      shadow read port (0 for rd_addr >= NREGS)
//   commit_count          commits seen, including R15/PC, saturating
//   done, pass, fail      sticky verdict
//   fail_reg, fail_value  first mismatching index and its shadow value
//   trace_*               only with MONITOR_TRACE_EN
module wb_commit_monitor #(
  parameter int NREGS       = 15,
  parameter int DATA_W      = 32,
  parameter int IDLE_LIMIT  = 16,
  parameter int TRACE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write_w,
  input  logic [3:0]        wa3_w,
  input  logic [DATA_W-1:0] result_w,
  input  logic              exp_we,
  input  logic [3:0]        exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       commit_count,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [3:0]        fail_reg,
  output logic [DATA_W-1:0] fail_value
`ifdef MONITOR_TRACE_EN
  ,
  input  logic              trace_pop,
  output logic              trace_valid,
  output logic [DATA_W+3:0] trace_data,
  output logic              trace_ovf
`endif
);

  localparam logic [3:0] NREGS_L  = 4'(NREGS);
  localparam logic [3:0] LAST_IDX = 4'(NREGS - 1);
  localparam logic [7:0] IDLE_L   = 8'(IDLE_LIMIT);

  if (IDLE_LIMIT < 1 || IDLE_LIMIT > 255) begin : g_idle_chk
    $error("IDLE_LIMIT must be in 1..255");
  end
  if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("TRACE_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {RUN, CHECK, DONE} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shadow_q [NREGS];
  logic [DATA_W-1:0] exp_q    [NREGS];
  logic [NREGS-1:0]  mask_q;
  logic [15:0]       count_q;
  logic [7:0]        idle_q;
  logic [3:0]        idx_q;
  logic              mismatch_q;
  logic              done_q, pass_q, fail_q;
  logic [3:0]        fail_reg_q;
  logic [DATA_W-1:0] fail_value_q;
  logic              idx_miss;

  // Entry under inspection this CHECK cycle differs from its armed expectation.
  assign idx_miss = mask_q[idx_q] && (shadow_q[idx_q] != exp_q[idx_q]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        shadow_q[i] <= '0;
        exp_q[i]    <= '0;
      end
      mask_q       <= '0;
      count_q      <= '0;
      idle_q       <= '0;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_reg_q   <= '0;
      fail_value_q <= '0;
      state_q      <= RUN;
    end else begin
      // Commits land in the shadow and the counter in every state.
      if (reg_write_w) begin
        if (wa3_w < NREGS_L) shadow_q[wa3_w] <= result_w;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end

      case (state_q)
        RUN: begin
          if (exp_we && (exp_addr < NREGS_L)) begin
            exp_q[exp_addr]  <= exp_data;
            mask_q[exp_addr] <= 1'b1;
          end
          // Leave on the edge where the idle count reaches the limit.
          if (reg_write_w) begin
            idle_q <= '0;
          end else if (idle_q >= IDLE_L - 8'd1) begin
            idle_q     <= IDLE_L;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
            state_q    <= CHECK;
          end else begin
            idle_q <= idle_q + 8'd1;
          end
        end

        CHECK: begin
          if (reg_write_w) begin
            // Program was not quiescent after all: discard partial results.
            state_q      <= RUN;
            idle_q       <= '0;
            mismatch_q   <= 1'b0;
            fail_reg_q   <= '0;
            fail_value_q <= '0;
          end else begin
            if (idx_miss && !mismatch_q) begin
              mismatch_q   <= 1'b1;
              fail_reg_q   <= idx_q;
              fail_value_q <= shadow_q[idx_q];
            end
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= !(mismatch_q || idx_miss);
              fail_q  <= mismatch_q || idx_miss;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end

        DONE:    state_q <= DONE;
        default: state_q <= RUN;
      endcase
    end
  end

  assign rd_data      = (rd_addr < NREGS_L) ? shadow_q[rd_addr] : '0;
  assign commit_count = count_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign fail         = fail_q;
  assign fail_reg     = fail_reg_q;
  assign fail_value   = fail_value_q;

`ifdef MONITOR_TRACE_EN
  localparam int PTR_W = $clog2(TRACE_DEPTH);

  logic [DATA_W+3:0] fifo_q [TRACE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    fill_q;
  logic              ovf_q;
  logic              fifo_full, do_push, do_pop;

  assign fifo_full = (fill_q == (PTR_W+1)'(TRACE_DEPTH));
  assign do_pop    = trace_pop && (fill_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push   = reg_write_w && (!fifo_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_ptr_q] <= {wa3_w, result_w};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (reg_write_w && !do_push) ovf_q <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + (PTR_W+1)'(1);
        2'b01:   fill_q <= fill_q - (PTR_W+1)'(1);
        default: fill_q <= fill_q;
      endcase
    end
  end

  assign trace_valid = (fill_q != '0);
  assign trace_data  = fifo_q[rd_ptr_q];
  assign trace_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_wb_commit_monitor.sv
`timescale 1ns/1ps
module tb_wb_commit_monitor;
  localparam int NREGS      = 15;
  localparam int DATA_W     = 32;
  localparam int IDLE_LIMIT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset       = 1'b1;
  logic              reg_write_w = 1'b0;
  logic [3:0]        wa3_w       = '0;
  logic [DATA_W-1:0] result_w    = '0;
  logic              exp_we      = 1'b0;
  logic [3:0]        exp_addr    = '0;
  logic [DATA_W-1:0] exp_data    = '0;
  logic [3:0]        rd_addr     = '0;
  logic [DATA_W-1:0] rd_data;
  logic [15:0]       commit_count;
  logic              done, pass, fail;
  logic [3:0]        fail_reg;
  logic [DATA_W-1:0] fail_value;
`ifdef MONITOR_TRACE_EN
  logic              trace_pop = 1'b0;
  logic              trace_valid;
  logic [DATA_W+3:0] trace_data;
  logic              trace_ovf;
`endif

  wb_commit_monitor #(
    .NREGS(NREGS), .DATA_W(DATA_W), .IDLE_LIMIT(IDLE_LIMIT), .TRACE_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .reg_write_w(reg_write_w), .wa3_w(wa3_w), .result_w(result_w),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .commit_count(commit_count),
    .done(done), .pass(pass), .fail(fail),
    .fail_reg(fail_reg), .fail_value(fail_value)
`ifdef MONITOR_TRACE_EN
    ,
    .trace_pop(trace_pop), .trace_valid(trace_valid),
    .trace_data(trace_data), .trace_ovf(trace_ovf)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: architectural view of what the monitor should report.
  // m_quiet counts commit-free edges since the last commit or reset; the
  // check window and the verdict follow directly from it.
  logic [DATA_W-1:0] m_sh   [NREGS];
  logic [DATA_W-1:0] m_ex   [NREGS];
  logic              m_mask [NREGS];
  int                m_cnt, m_quiet;
  logic              m_done, m_pass, m_fail;
  logic [3:0]        m_freg;
  logic [DATA_W-1:0] m_fval;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        m_sh[i] = '0; m_ex[i] = '0; m_mask[i] = 1'b0;
      end
      m_cnt = 0; m_quiet = 0;
      m_done = 1'b0; m_pass = 1'b0; m_fail = 1'b0;
      m_freg = '0; m_fval = '0;
    end else begin
      // Expected-table writes only land while still waiting for quiescence.
      if (!m_done && m_quiet < IDLE_LIMIT && exp_we && exp_addr < NREGS) begin
        m_ex[exp_addr]   = exp_data;
        m_mask[exp_addr] = 1'b1;
      end
      if (reg_write_w) begin
        if (wa3_w < NREGS) m_sh[wa3_w] = result_w;
        if (m_cnt < 65535) m_cnt++;
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (!m_done && m_quiet == IDLE_LIMIT + NREGS) begin
          m_done = 1'b1; m_fail = 1'b0;
          for (int i = 0; i < NREGS; i++) begin
            if (!m_fail && m_mask[i] && m_sh[i] != m_ex[i]) begin
              m_fail = 1'b1; m_freg = 4'(i); m_fval = m_sh[i];
            end
          end
          m_pass = !m_fail;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    rd_addr = 4'($urandom_range(0, 15));
    #1;
    chk("commit_count", commit_count, m_cnt);
    chk("done", done, m_done);
    chk("pass", pass, m_pass);
    chk("fail", fail, m_fail);
    chk("rd_data", rd_data, (rd_addr < NREGS) ? m_sh[rd_addr] : '0);
    if (m_done) begin
      chk("fail_reg", fail_reg, m_freg);
      chk("fail_value", fail_value, m_fval);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic commit(input logic [3:0] wa, input logic [DATA_W-1:0] wd);
    reg_write_w = 1'b1; wa3_w = wa; result_w = wd;
    tick();
    reg_write_w = 1'b0;
  endtask

  task automatic load(input logic [3:0] ea, input logic [DATA_W-1:0] ed);
    exp_we = 1'b1; exp_addr = ea; exp_data = ed;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [DATA_W-1:0] want);
    rd_addr = a; #1;
    chk(tag, rd_data, want);
  endtask

  int vals [6] = '{9, 15, 8, 30, 1, 8};
  int blen, gap;

  initial begin
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_done", done, 1'b0);
    chk("rst_count", commit_count, 16'd0);
    for (int a = 0; a < 16; a++) rd_check("rst_rd", 4'(a), '0);

    // Matching program: verdict 31 cycles after the last commit
    for (int i = 0; i < 6; i++) load(4'(i), vals[i]);
    for (int i = 0; i < 6; i++) commit(4'(i), vals[i]);
    idle(30);
    chk("t1_done_early", done, 1'b0);
    idle(1);
    chk("t1_done", done, 1'b1);
    chk("t1_pass", pass, 1'b1);
    chk("t1_fail", fail, 1'b0);
    commit(4'd0, 32'd77);
    chk("t1_frozen_pass", pass, 1'b1);
    rd_check("t1_late_rd", 4'd0, 32'd77);

    // Single mismatch on R3
    do_reset();
    for (int i = 0; i < 6; i++) load(4'(i), vals[i]);
    for (int i = 0; i < 6; i++) commit(4'(i), (i == 3) ? 29 : vals[i]);
    idle(31);
    chk("t2_fail", fail, 1'b1);
    chk("t2_pass", pass, 1'b0);
    chk("t2_fail_reg", fail_reg, 4'd3);
    chk("t2_fail_value", fail_value, 32'd29);

    // Commit during CHECK cycle 4 aborts and the check reruns later
    do_reset();
    for (int i = 0; i < 6; i++) load(4'(i), vals[i]);
    for (int i = 0; i < 6; i++) commit(4'(i), vals[i]);
    idle(19);
    commit(4'd2, 32'd8);
    chk("t3_abort_done", done, 1'b0);
    rd_check("t3_rd_r2", 4'd2, 32'd8);
    idle(30);
    chk("t3_rerun_early", done, 1'b0);
    idle(1);
    chk("t3_rerun_done", done, 1'b1);
    chk("t3_rerun_pass", pass, 1'b1);

    // PC write is counted but not stored
    do_reset();
    commit(4'd15, 32'h40);
    commit(4'd4, 32'd1);
    chk("t4_count", commit_count, 16'd2);
    for (int a = 0; a < 16; a++) rd_check("t4_rd", 4'(a), (a == 4) ? 32'd1 : 32'd0);

    // Reset in the middle of CHECK
    do_reset();
    load(4'd1, 32'd3);
    commit(4'd1, 32'd5);
    idle(20);
    do_reset();
    chk("t5_done", done, 1'b0);
    chk("t5_pass", pass, 1'b0);
    chk("t5_fail", fail, 1'b0);
    chk("t5_count", commit_count, 16'd0);
    chk("t5_fail_reg", fail_reg, 4'd0);
    for (int a = 0; a < 16; a++) rd_check("t5_rd", 4'(a), '0);

`ifdef MONITOR_TRACE_EN
    // Trace FIFO overflow and ordering
    do_reset();
    for (int i = 0; i < 9; i++) commit(4'(i), 32'(100 + i));
    chk("tr_ovf", trace_ovf, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("tr_valid", trace_valid, 1'b1);
      chk("tr_data", trace_data, {4'(i), 32'(100 + i)});
      trace_pop = 1'b1; tick(); trace_pop = 1'b0;
    end
    chk("tr_empty", trace_valid, 1'b0);
    // Push and pop together on a full FIFO does not overflow
    do_reset();
    for (int i = 0; i < 8; i++) commit(4'(i), 32'(i));
    trace_pop = 1'b1; commit(4'd9, 32'd99); trace_pop = 1'b0;
    chk("tr_pushpop_ovf", trace_ovf, 1'b0);
    chk("tr_pushpop_head", trace_data, {4'd1, 32'd1});
`endif

    // Randomized traffic: bursts of commits/table writes, idle gaps that
    // sometimes reach CHECK/DONE, stray commits to abort checks, rare resets.
    do_reset();
    for (int b = 0; b < 150; b++) begin
      blen = $urandom_range(1, 8);
      for (int k = 0; k < blen; k++) begin
        reg_write_w = ($urandom_range(0, 9) < 7);
        wa3_w       = 4'($urandom_range(0, 15));
        result_w    = $urandom_range(0, 3);
        exp_we      = ($urandom_range(0, 9) < 3);
        exp_addr    = 4'($urandom_range(0, 15));
        exp_data    = $urandom_range(0, 3);
        reset       = ($urandom_range(0, 99) == 0);
        tick();
      end
      reset = 1'b0;
      gap = $urandom_range(0, 40);
      for (int k = 0; k < gap; k++) begin
        reg_write_w = ($urandom_range(0, 99) < 3);
        wa3_w       = 4'($urandom_range(0, 15));
        result_w    = $urandom_range(0, 3);
        exp_we      = ($urandom_range(0, 9) == 0);
        exp_addr    = 4'($urandom_range(0, 15));
        exp_data    = $urandom_range(0, 3);
        tick();
      end
      reg_write_w = 1'b0;
      exp_we      = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
